// File: rtl/triangle_setup_if.sv
// Bundle of request, vertex and result signals between the projection stage
// and triangle_setup.
interface triangle_setup_if;
  // start is a level request. It is taken on a rising edge while the block is idle,
  // or after finish has been shown. finish then stays high until the next start is taken.
  logic               start;
  logic signed [31:0] x1, y1, x2, y2, x3, y3;
  logic               busy;
  logic               finish;
  logic signed [31:0] sx1, sy1, sx2, sy2, sx3, sy3;
  logic signed [63:0] area2;
  logic [15:0]        bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic               offscreen;
  logic               culled;

  modport master (
    output start, x1, y1, x2, y2, x3, y3,
    input  busy, finish, sx1, sy1, sx2, sy2, sx3, sy3, area2,
    input  bb_xmin, bb_xmax, bb_ymin, bb_ymax, offscreen, culled
  );

  modport slave (
    input  start, x1, y1, x2, y2, x3, y3,
    output busy, finish, sx1, sy1, sx2, sy2, sx3, sy3, area2,
    output bb_xmin, bb_xmax, bb_ymin, bb_ymax, offscreen, culled
  );
endinterface

// File: rtl/triangle_setup.sv
// Triangle setup: maps centre-origin vertices to screen space, computes twice the
// signed area and a clamped bounding box. Optional BACKFACE_CULL_EN enables culling.
module triangle_setup #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  triangle_setup_if.slave  bus,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MAP  = 3'd1,
    S_AREA = 3'd2,
    S_BBOX = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic signed [31:0] HALF_W = 32'(SCREEN_W / 2);
  localparam logic signed [31:0] HALF_H = 32'(SCREEN_H / 2);
  localparam logic signed [31:0] X_LAST = 32'(SCREEN_W - 1);
  localparam logic signed [31:0] Y_LAST = 32'(SCREEN_H - 1);

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               finish_q, finish_d;
  logic signed [31:0] vx_q [3];
  logic signed [31:0] vx_d [3];
  logic signed [31:0] vy_q [3];
  logic signed [31:0] vy_d [3];
  logic signed [31:0] sx_q [3];
  logic signed [31:0] sx_d [3];
  logic signed [31:0] sy_q [3];
  logic signed [31:0] sy_d [3];
  logic signed [63:0] area2_q, area2_d;
  logic [15:0]        bb_xmin_q, bb_xmin_d;
  logic [15:0]        bb_xmax_q, bb_xmax_d;
  logic [15:0]        bb_ymin_q, bb_ymin_d;
  logic [15:0]        bb_ymax_q, bb_ymax_d;
  logic               offscreen_q, offscreen_d;
  logic               culled_q, culled_d;

  logic signed [32:0] dx21, dy21, dx31, dy31;
  logic signed [63:0] prod_a, prod_b;
  logic signed [31:0] xmin, xmax, ymin, ymax;
  logic               off_raw;

  function automatic logic [15:0] clamp16(input logic signed [31:0] v,
                                          input logic signed [31:0] hi);
    if (v < 0)       return 16'd0;
    else if (v > hi) return hi[15:0];
    else             return v[15:0];
  endfunction

  always_comb begin
    // 33-bit differences keep full precision for any 32-bit screen coordinate.
    dx21   = {sx_q[1][31], sx_q[1]} - {sx_q[0][31], sx_q[0]};
    dy21   = {sy_q[1][31], sy_q[1]} - {sy_q[0][31], sy_q[0]};
    dx31   = {sx_q[2][31], sx_q[2]} - {sx_q[0][31], sx_q[0]};
    dy31   = {sy_q[2][31], sy_q[2]} - {sy_q[0][31], sy_q[0]};
    prod_a = {{31{dx21[32]}}, dx21} * {{31{dy31[32]}}, dy31};
    prod_b = {{31{dx31[32]}}, dx31} * {{31{dy21[32]}}, dy21};

    xmin = sx_q[0];
    xmax = sx_q[0];
    ymin = sy_q[0];
    ymax = sy_q[0];
    for (int i = 1; i < 3; i++) begin
      if (sx_q[i] < xmin) xmin = sx_q[i];
      if (sx_q[i] > xmax) xmax = sx_q[i];
      if (sy_q[i] < ymin) ymin = sy_q[i];
      if (sy_q[i] > ymax) ymax = sy_q[i];
    end
    off_raw = (xmax < 0) || (xmin > X_LAST) || (ymax < 0) || (ymin > Y_LAST);
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    finish_d    = finish_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    area2_d     = area2_q;
    bb_xmin_d   = bb_xmin_q;
    bb_xmax_d   = bb_xmax_q;
    bb_ymin_d   = bb_ymin_q;
    bb_ymax_d   = bb_ymax_q;
    offscreen_d = offscreen_q;
    culled_d    = culled_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // First DONE cycle only raises finish, so a held start still sees a one-cycle pulse.
        if (state_q == S_DONE && !finish_q) begin
          finish_d = 1'b1;
          busy_d   = 1'b0;
        end else if (bus.start) begin
          vx_d     = '{bus.x1, bus.x2, bus.x3};
          vy_d     = '{bus.y1, bus.y2, bus.y3};
          finish_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_MAP;
        end
      end
      S_MAP: begin
        for (int i = 0; i < 3; i++) begin
          sx_d[i] = vx_q[i] + HALF_W;
          sy_d[i] = HALF_H - vy_q[i];
        end
        state_d = S_AREA;
      end
      S_AREA: begin
        area2_d = prod_a - prod_b;
        state_d = S_BBOX;
      end
      S_BBOX: begin
        offscreen_d = off_raw;
        bb_xmin_d   = off_raw ? 16'd0 : clamp16(xmin, X_LAST);
        bb_xmax_d   = off_raw ? 16'd0 : clamp16(xmax, X_LAST);
        bb_ymin_d   = off_raw ? 16'd0 : clamp16(ymin, Y_LAST);
        bb_ymax_d   = off_raw ? 16'd0 : clamp16(ymax, Y_LAST);
`ifdef BACKFACE_CULL_EN
        culled_d    = (area2_q <= 64'sd0);
`else
        culled_d    = 1'b0;
`endif
        state_d     = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      vx_q        <= '{default: '0};
      vy_q        <= '{default: '0};
      sx_q        <= '{default: '0};
      sy_q        <= '{default: '0};
      area2_q     <= '0;
      bb_xmin_q   <= '0;
      bb_xmax_q   <= '0;
      bb_ymin_q   <= '0;
      bb_ymax_q   <= '0;
      offscreen_q <= 1'b0;
      culled_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      area2_q     <= area2_d;
      bb_xmin_q   <= bb_xmin_d;
      bb_xmax_q   <= bb_xmax_d;
      bb_ymin_q   <= bb_ymin_d;
      bb_ymax_q   <= bb_ymax_d;
      offscreen_q <= offscreen_d;
      culled_q    <= culled_d;
    end
  end

  assign state_dbg     = state_q;
  assign bus.busy      = busy_q;
  assign bus.finish    = finish_q;
  assign bus.sx1       = sx_q[0];
  assign bus.sy1       = sy_q[0];
  assign bus.sx2       = sx_q[1];
  assign bus.sy2       = sy_q[1];
  assign bus.sx3       = sx_q[2];
  assign bus.sy3       = sy_q[2];
  assign bus.area2     = area2_q;
  assign bus.bb_xmin   = bb_xmin_q;
  assign bus.bb_xmax   = bb_xmax_q;
  assign bus.bb_ymin   = bb_ymin_q;
  assign bus.bb_ymax   = bb_ymax_q;
  assign bus.offscreen = offscreen_q;
  assign bus.culled    = culled_q;

endmodule

// File: doc/triangle_setup.md
TRIANGLE_SETUP -- requirements
Module: triangle_setup

Interface
REQ-001 Parameter SCREEN_W, default 640, screen width in pixels (even, 2..32767).
REQ-002 Parameter SCREEN_H, default 480, screen height in pixels (even, 2..32767).
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  level request; sampled on rising clk edge; fed by the projection stage.
REQ-006 x1,y1,x2,y2,x3,y3  in  32 signed  projected vertex coordinates, origin at screen centre, +y up.
REQ-007 busy  out  1  high while the block is processing a triangle.
REQ-008 finish  out  1  results valid; level signal, held until the next accepted start.
REQ-009 sx1,sy1,sx2,sy2,sx3,sy3  out  32 signed  screen coordinates, origin top-left, +y down.
REQ-010 area2  out  64 signed  twice the signed triangle area in screen space.
REQ-011 bb_xmin,bb_xmax,bb_ymin,bb_ymax  out  16 unsigned  clamped bounding box.
REQ-012 offscreen  out  1  bounding box lies wholly outside the screen.
REQ-013 culled  out  1  triangle rejected as back-facing or degenerate.

Function
REQ-014 FSM states: IDLE, MAP, AREA, BBOX, DONE; one state per clock.
REQ-015 IDLE or DONE with start=1 at an edge: latch all six inputs, clear finish, set busy, go to MAP.
REQ-016 start is ignored in MAP, AREA and BBOX; in-flight inputs are not overwritten.
REQ-017 MAP: sxN = xN + SCREEN_W/2; syN = SCREEN_H/2 - yN; 32-bit wrap on overflow.
REQ-018 AREA: area2 = (sx2-sx1)*(sy3-sy1) - (sx3-sx1)*(sy2-sy1); differences sign-extended to 33 bits, products and subtraction in 64 bits.
REQ-019 BBOX: raw min/max over the three sx and over the three sy.
REQ-020 offscreen = 1 when raw xmax<0, xmin>SCREEN_W-1, ymax<0 or ymin>SCREEN_H-1.
REQ-021 offscreen=0: each bbox bound is clamped to [0,SCREEN_W-1] or [0,SCREEN_H-1]; offscreen=1: all four bbox outputs are 0.
REQ-022 BBOX also evaluates culled per REQ-030/REQ-031, then the FSM goes to DONE.
REQ-023 DONE: finish=1 and busy=0; the FSM stays in DONE until start.
REQ-024 Latency: finish rises on the 4th rising edge after the edge that accepted start.
REQ-025 Outputs hold their last values in DONE and through the following IDLE/restart until overwritten by their computing state.
REQ-026 start held high continuously: a new triangle is accepted on the edge after DONE is reached (the finish pulse lasts one cycle).

Reset
REQ-027 rst_n=0: immediately forces state IDLE, busy=0, finish=0, culled=0, offscreen=0; all coordinate, area and bbox outputs are 0.
REQ-028 Reset asserted mid-operation aborts the triangle; no finish is produced for it.
REQ-029 After rst_n deasserts, the first rising edge with start=1 is accepted.

Configuration
REQ-030 With BACKFACE_CULL_EN defined: culled=1 when area2<=0 (clockwise or degenerate in screen space); otherwise culled=0.
REQ-031 Without BACKFACE_CULL_EN: culled is constant 0; area2 is still computed and output.

Verification
REQ-032 Nominal (inputs (26,30),(9,18),(18,36), defaults): the bench checks all of the following.
- Screen coordinates: (346,210),(329,222),(338,204).
- area2 = 198.
- Bounding box: x 329..346, y 204..222.
- offscreen = 0; culled = 0.
- finish rises 4 edges after start.
REQ-033 Reversed winding: vertices 2 and 3 of REQ-032 are swapped.
- area2 = -198.
- culled = 1 with BACKFACE_CULL_EN; culled = 0 without it.
REQ-034 Clamp and offscreen cases:
- (-400,0),(0,10),(0,-10) gives bb_xmin=0, bb_xmax=320, offscreen=0.
- All x=400 gives offscreen=1 with all bbox outputs 0.
REQ-035 Degenerate triangle (0,0),(10,10),(20,20) gives area2=0 and culled=1 with BACKFACE_CULL_EN.
REQ-036 rst_n pulsed low during AREA gives busy=0, finish=0 and all outputs 0 immediately, with no finish pulse; the next start completes normally in 4 edges.
